// File: rtl/motion_estimation_if.sv
// Request/result bundle between a block-matching client and motion_estimation.
// Carries the frame/macroblock data, start strobe and the best-vector result.
interface motion_estimation_if #(
    parameter int MB_SIZE        = 4,
    parameter int PIXEL_WIDTH    = 8,
    parameter int REF_FRAME_SIZE = 8
);
    localparam int SAD_W = PIXEL_WIDTH + $clog2(MB_SIZE * MB_SIZE);

    logic                   start;
    logic [PIXEL_WIDTH-1:0] ref_frame [0:REF_FRAME_SIZE-1][0:REF_FRAME_SIZE-1];
    logic [PIXEL_WIDTH-1:0] curr_mb   [0:MB_SIZE-1][0:MB_SIZE-1];
    logic [5:0]             mv_x;
    logic [5:0]             mv_y;
    logic [SAD_W-1:0]       min_sad;
    logic                   busy;
    logic                   done;

    modport master (
        output start, ref_frame, curr_mb,
        input  mv_x, mv_y, min_sad, busy, done
    );

    modport slave (
        input  start, ref_frame, curr_mb,
        output mv_x, mv_y, min_sad, busy, done
    );
endinterface

// File: rtl/motion_estimation.sv
// Full-search SAD block matcher, one macroblock row per cycle, raster order.
// Optional ME_EARLY_TERM_EN abandons a candidate once its partial SAD loses.
module motion_estimation #(
    parameter int MB_SIZE        = 4,
    parameter int PIXEL_WIDTH    = 8,
    parameter int REF_FRAME_SIZE = 8
) (
    input  logic               clk,
    input  logic               reset,
    motion_estimation_if.slave bus
);
    localparam int SRCH_N = REF_FRAME_SIZE - MB_SIZE + 1;
    localparam int SAD_W  = PIXEL_WIDTH + $clog2(MB_SIZE * MB_SIZE);
    localparam int RW     = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
    localparam int FW     = (REF_FRAME_SIZE > 1) ? $clog2(REF_FRAME_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [5:0]       cx_q, cx_d;
    logic [5:0]       cy_q, cy_d;
    logic [RW-1:0]    row_q, row_d;
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [5:0]       best_x_q, best_x_d;
    logic [5:0]       best_y_q, best_y_d;
    logic [5:0]       mv_x_q, mv_x_d;
    logic [5:0]       mv_y_q, mv_y_d;
    logic [SAD_W-1:0] min_sad_q, min_sad_d;
    logic             done_q, done_d;

    logic [SAD_W-1:0]       row_sad;
    logic [SAD_W-1:0]       cand_sad;
    logic [5:0]             ry;
    logic [5:0]             cxj;
    logic signed [PIXEL_WIDTH:0] diff;
    logic [PIXEL_WIDTH:0]   mag;
    logic                   last_row;
    logic                   last_cx;
    logic                   last_cy;
    logic                   next_cand;

    // One row of the current candidate; the 9-bit difference cannot overflow.
    always_comb begin
        row_sad = '0;
        diff    = '0;
        mag     = '0;
        cxj     = '0;
        ry      = cy_q + 6'(row_q);
        for (int j = 0; j < MB_SIZE; j++) begin
            cxj     = cx_q + 6'(j);
            diff    = $signed({1'b0, bus.curr_mb[row_q][j]})
                    - $signed({1'b0, bus.ref_frame[ry[FW-1:0]][cxj[FW-1:0]]});
            mag     = diff[PIXEL_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
            row_sad = row_sad + SAD_W'(mag);
        end
    end

    assign cand_sad = acc_q + row_sad;
    assign last_row = (row_q == RW'(MB_SIZE - 1));
    assign last_cx  = (cx_q == 6'(SRCH_N - 1));
    assign last_cy  = (cy_q == 6'(SRCH_N - 1));

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        row_d      = row_q;
        acc_d      = acc_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        min_sad_d  = min_sad_q;
        done_d     = 1'b0;
        next_cand  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SEARCH;
                    cx_d       = '0;
                    cy_d       = '0;
                    row_d      = '0;
                    acc_d      = '0;
                    best_sad_d = '1;
                end
            end
            SEARCH: begin
                // Strict compare keeps the earliest raster candidate on ties.
                if (last_row) begin
                    next_cand = 1'b1;
                    if (cand_sad < best_sad_q) begin
                        best_sad_d = cand_sad;
                        best_x_d   = cx_q;
                        best_y_d   = cy_q;
                    end
                end
`ifdef ME_EARLY_TERM_EN
                else if (cand_sad >= best_sad_q) begin
                    next_cand = 1'b1;
                end
`endif
                else begin
                    acc_d = cand_sad;
                    row_d = row_q + RW'(1);
                end
                if (next_cand) begin
                    acc_d = '0;
                    row_d = '0;
                    if (last_cx) begin
                        cx_d = '0;
                        if (last_cy) begin
                            state_d = DONE;
                        end else begin
                            cy_d = cy_q + 6'd1;
                        end
                    end else begin
                        cx_d = cx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                mv_x_d    = best_x_q;
                mv_y_d    = best_y_q;
                min_sad_d = best_sad_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            min_sad_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            min_sad_q  <= min_sad_d;
            done_q     <= done_d;
        end
    end

    assign bus.mv_x    = mv_x_q;
    assign bus.mv_y    = mv_y_q;
    assign bus.min_sad = min_sad_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_motion_estimation.sv
// Directed bench for motion_estimation: hand-computed vectors, SADs, latency.
// Latency expectations relax when ME_EARLY_TERM_EN is defined.
module tb_motion_estimation;
    localparam int MB = 4;
    localparam int PW = 8;
    localparam int RF = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    motion_estimation_if #(
        .MB_SIZE(MB), .PIXEL_WIDTH(PW), .REF_FRAME_SIZE(RF)
    ) bus ();

    motion_estimation #(
        .MB_SIZE(MB), .PIXEL_WIDTH(PW), .REF_FRAME_SIZE(RF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill(input int mode);
        for (int r = 0; r < RF; r++) begin
            for (int c = 0; c < RF; c++) begin
                case (mode)
                    0: bus.ref_frame[r][c] = 8'd0;
                    1: bus.ref_frame[r][c] = 8'((r * 8 + c) * 7 + 3);
                    2: bus.ref_frame[r][c] = 8'd10;
                    3: bus.ref_frame[r][c] = 8'(r + c);
                    default: bus.ref_frame[r][c] = 8'd0;
                endcase
            end
        end
        for (int i = 0; i < MB; i++) begin
            for (int j = 0; j < MB; j++) begin
                case (mode)
                    0: bus.curr_mb[i][j] = 8'd0;
                    1: bus.curr_mb[i][j] = 8'(((2 + i) * 8 + 3 + j) * 7 + 3);
                    2: bus.curr_mb[i][j] = 8'd10;
                    3: bus.curr_mb[i][j] = 8'd6;
                    default: bus.curr_mb[i][j] = 8'd255;
                endcase
            end
        end
    endtask

    // Pulses start, then waits (bounded) for done; returns edges to done.
    task automatic run_search(output int lat, output int busy_n);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 400) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk);
            #1;
            lat++;
            checks++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%b done=%b required not both high",
                         bus.busy, bus.done);
            end
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout got done=%b after %0d cycles required 1", bus.done, lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b required 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b required 0", bus.done);
        end
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0) begin
            errors++; $display("FAIL reset_mv got (%0d,%0d) required (0,0)", bus.mv_x, bus.mv_y);
        end
        checks++;
        if (bus.min_sad !== 12'd0) begin
            errors++; $display("FAIL reset_sad got %0d required 0", bus.min_sad);
        end
    endtask

    task automatic test_zero;
        int lat, bn;
        fill(0);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd0) begin
            errors++;
            $display("FAIL zero_result got (%0d,%0d) sad %0d required (0,0) sad 0",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
`ifndef ME_EARLY_TERM_EN
        checks++;
        if (lat !== 101) begin
            errors++; $display("FAIL zero_latency got %0d required 101", lat);
        end
        checks++;
        if (bn !== 101) begin
            errors++; $display("FAIL zero_busy_cycles got %0d required 101", bn);
        end
`else
        checks++;
        if (lat > 101) begin
            errors++; $display("FAIL zero_latency got %0d required <=101", lat);
        end
`endif
    endtask

    task automatic test_unique;
        int lat, bn;
        fill(1);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd3 || bus.mv_y !== 6'd2 || bus.min_sad !== 12'd0) begin
            errors++;
            $display("FAIL unique_result got (%0d,%0d) sad %0d required (3,2) sad 0",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
        checks++;
`ifdef ME_EARLY_TERM_EN
        if (lat >= 101) begin
            errors++; $display("FAIL unique_latency got %0d required <101", lat);
        end
`else
        if (lat !== 101) begin
            errors++; $display("FAIL unique_latency got %0d required 101", lat);
        end
`endif
    endtask

    task automatic test_tie;
        int lat, bn;
        fill(2);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd0) begin
            errors++;
            $display("FAIL tie_result got (%0d,%0d) sad %0d required (0,0) sad 0",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    // ref = r+c, curr = 6: SAD depends on cx+cy, minimum 20 at cx+cy=3.
    task automatic test_diag;
        int lat, bn;
        fill(3);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd3 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd20) begin
            errors++;
            $display("FAIL diag_result got (%0d,%0d) sad %0d required (3,0) sad 20",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    task automatic test_max;
        int lat, bn;
        fill(4);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd4080) begin
            errors++;
            $display("FAIL max_result got (%0d,%0d) sad %0d required (0,0) sad 4080",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    task automatic test_abort;
        int n_done;
        int cyc;
        fill(3);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_before got %b required 1", bus.busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_flags got busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd0) begin
            errors++;
            $display("FAIL abort_outputs got (%0d,%0d) sad %0d required (0,0) sad 0",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
        n_done = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++; $display("FAIL abort_no_done got %0d pulses required 0", n_done);
        end
        // Fresh search with an ignored mid-search start.
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_done = 0;
        cyc = 0;
        while (cyc < 250) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 1) begin
            errors++; $display("FAIL abort_one_done got %0d pulses required 1", n_done);
        end
        checks++;
        if (bus.mv_x !== 6'd3 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd20) begin
            errors++;
            $display("FAIL abort_rerun got (%0d,%0d) sad %0d required (3,0) sad 20",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        fill(1);
        @(negedge clk);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd3 || bus.mv_y !== 6'd2 || bus.min_sad !== 12'd0) begin
            errors++;
            $display("FAIL b2b_first got (%0d,%0d) sad %0d required (3,2) sad 0",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
        fill(4);
        run_search(lat, bn);
        checks++;
        if (bus.mv_x !== 6'd0 || bus.mv_y !== 6'd0 || bus.min_sad !== 12'd4080) begin
            errors++;
            $display("FAIL b2b_second got (%0d,%0d) sad %0d required (0,0) sad 4080",
                     bus.mv_x, bus.mv_y, bus.min_sad);
        end
`ifndef ME_EARLY_TERM_EN
        checks++;
        if (lat !== 101) begin
            errors++; $display("FAIL b2b_latency got %0d required 101", lat);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse got done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
        checks++;
        if (bus.min_sad !== 12'd4080 || bus.mv_x !== 6'd0) begin
            errors++;
            $display("FAIL b2b_hold got sad %0d mv_x %0d required 4080 0",
                     bus.min_sad, bus.mv_x);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_unique();
        test_tie();
        test_diag();
        test_max();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
